sprite_position_table: RTL and testbench
========================================

SPRITE_POSITION_TABLE -- requirements
Module: sprite_position_table

Interface
REQ-001 SHALL have parameter X_MAX, default 639, meaning largest legal sprite x coordinate.
REQ-002 SHALL have parameter Y_MAX, default 479, meaning largest legal sprite y coordinate.
REQ-003 SHALL have parameter PULSE_LEN, default 4, meaning refresh_image high time in clocks (range 1..15).
REQ-004 SHALL have port clk_clk, input, 1, meaning the single system clock.
REQ-005 SHALL have port reset_reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port position_table_in, input, 32, meaning position command word from the Qsys PIO position_table_export.
REQ-007 SHALL have port frame_start, input, 1, meaning one-cycle video frame-start strobe, synchronous to clk_clk.
REQ-008 SHALL have port refresh_image, output, 1, meaning frame-done pulse to the Qsys refresh_image PIO.
REQ-009 SHALL have port rd_id, input, 3, meaning sprite index queried by the renderer.
REQ-010 SHALL have ports rd_x (output, 10), rd_y (output, 9), rd_dir (output, 3), rd_vis (output, 1), meaning the active-bank entry for rd_id.
REQ-011 SHALL have port pending, output, 1, meaning the shadow bank holds uncommitted writes.
REQ-012 SHALL have port err_count, output, 8, meaning count of rejected commands.

Function
REQ-013 SHALL decode the command word as: [31] toggle, [30:28] id, [27:18] x, [17:9] y, [8:6] dir, [5] visible, [4:0] ignored.
REQ-014 SHALL register position_table_in once and treat a change of registered bit 31 versus its previous registered value as exactly one write command.
REQ-015 SHALL write the command fields into shadow entry id on the clock after detection; total latency from input change to shadow update is 2 clocks.
REQ-016 SHALL set pending on every accepted write and clear it on commit.
REQ-017 SHALL hold 8 shadow and 8 active entries; the renderer reads only the active bank.
REQ-018 SHALL implement FSM IDLE -> COMMIT -> NOTIFY -> IDLE: frame_start in IDLE enters COMMIT; COMMIT lasts 1 clock; NOTIFY lasts PULSE_LEN clocks and then returns to IDLE.
REQ-019 SHALL copy all 8 shadow entries to the active bank in COMMIT only if pending=1; otherwise leave the active bank unchanged.
REQ-020 SHALL drive refresh_image high during NOTIFY and low otherwise, registered.
REQ-021 SHALL, on frame_start during COMMIT or NOTIFY, re-enter COMMIT on the next clock and restart the pulse count.
REQ-022 SHALL, when a shadow write and COMMIT occur in the same clock, commit the pre-write shadow value and leave pending=1, so that set wins over clear.
REQ-023 SHALL return rd_x/rd_y/rd_dir/rd_vis with 1 clock latency from rd_id, from the active bank as it stood after the previous clock edge.
REQ-024 SHALL apply repeated writes to the same id between commits so that the last write wins.

Reset
REQ-025 SHALL, while reset_reset_n=0, asynchronously force: all shadow and active fields 0, previous-toggle 0, FSM IDLE, refresh_image 0, pending 0, err_count 0, rd_* 0.
REQ-026 SHALL require, because the previous toggle resets to 0, that the first command after reset carry toggle=1.
REQ-027 SHALL abort any COMMIT/NOTIFY in progress on reset, with no partial-copy guarantee needed because both banks clear.

Configuration
REQ-028 SHALL, with SPRITE_BOUNDS_CHECK_EN defined, discard any command with x>X_MAX or y>Y_MAX (shadow and pending unchanged) and increment err_count, saturating at 255.
REQ-029 SHALL, without SPRITE_BOUNDS_CHECK_EN, store all commands unchecked and tie err_count to 0.

Verification
REQ-030 SHALL cover: after reset, write word toggle=1, id=2, x=100, y=50, dir=3, vis=1, then frame_start -> pending=1 after 2 clocks; rd_id=2 returns x=100, y=50, dir=3, vis=1 after commit; refresh_image high for 4 clocks.
REQ-031 SHALL cover: frame_start with pending=0 -> active bank unchanged; refresh_image still pulses for PULSE_LEN clocks.
REQ-032 SHALL cover: shadow write of id=5 in the same clock as COMMIT -> active id=5 keeps its old value and pending=1; the next frame_start commits the new value.
REQ-033 SHALL cover: with SPRITE_BOUNDS_CHECK_EN, write x=700 -> entry unchanged and err_count=1; 300 bad writes -> err_count=255.
REQ-034 SHALL cover: frame_start asserted on NOTIFY clock 2 -> COMMIT repeats and refresh_image stays high for 4 further clocks after the new COMMIT.
REQ-035 SHALL cover: reset asserted mid-NOTIFY -> refresh_image=0 immediately; all rd_* read 0 after release.

Source files
------------

// File: rtl/sprite_position_table.sv
// Double-buffered sprite position table: PIO toggle-handshake writes go to a shadow bank that is
// committed to the renderer-visible active bank on frame_start. Optional: SPRITE_BOUNDS_CHECK_EN.
module sprite_position_table #(
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned Y_MAX     = 479,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] position_table_in,
    input  logic        frame_start,
    output logic        refresh_image,
    input  logic [2:0]  rd_id,
    output logic [9:0]  rd_x,
    output logic [8:0]  rd_y,
    output logic [2:0]  rd_dir,
    output logic        rd_vis,
    output logic        pending,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        StIdle,
        StCommit,
        StNotify
    } state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] dir;
        logic       vis;
    } entry_t;

    localparam logic [3:0] LastCnt = 4'(PULSE_LEN - 1);

    logic [31:5]       cmd_q;
    logic              tog_prev_q;
    entry_t [7:0]      shadow_q, shadow_d;
    entry_t [7:0]      active_q, active_d;
    entry_t            rd_q;
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              refresh_q;
    logic              pending_q, pending_d;
    logic [7:0]        err_q, err_d;

    logic              cmd_valid;
    logic              bounds_ok;
    logic              wr_en;
    logic              commit;
    logic [2:0]        cmd_id;
    entry_t            cmd_entry;

    logic              unused_low_bits;
    assign unused_low_bits = ^position_table_in[4:0];

    assign cmd_id          = cmd_q[30:28];
    assign cmd_entry.x     = cmd_q[27:18];
    assign cmd_entry.y     = cmd_q[17:9];
    assign cmd_entry.dir   = cmd_q[8:6];
    assign cmd_entry.vis   = cmd_q[5];

    // Each edge of the registered toggle bit is one command.
    assign cmd_valid = cmd_q[31] ^ tog_prev_q;
    assign bounds_ok = (32'(cmd_entry.x) <= X_MAX) && (32'(cmd_entry.y) <= Y_MAX);

`ifdef SPRITE_BOUNDS_CHECK_EN
    assign wr_en = cmd_valid & bounds_ok;
`else
    logic unused_bounds;
    assign unused_bounds = bounds_ok;
    assign wr_en = cmd_valid;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                commit = 1'b1;
                if (!frame_start) begin
                    state_d = StNotify;
                    cnt_d   = '0;
                end
            end
            StNotify: begin
                if (frame_start) begin
                    state_d = StCommit;
                end else if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (wr_en) begin
            shadow_d[cmd_id] = cmd_entry;
        end
        // Copy takes the pre-write shadow; a coincident write keeps pending set.
        if (commit && pending_q) begin
            active_d = shadow_q;
        end
        if (commit) begin
            pending_d = 1'b0;
        end
        if (wr_en) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
`ifdef SPRITE_BOUNDS_CHECK_EN
        if (cmd_valid && !bounds_ok && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
`else
        err_d = '0;
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_q      <= '0;
            tog_prev_q <= 1'b0;
            shadow_q   <= '0;
            active_q   <= '0;
            rd_q       <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            refresh_q  <= 1'b0;
            pending_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            cmd_q      <= position_table_in[31:5];
            tog_prev_q <= cmd_q[31];
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            rd_q       <= active_q[rd_id];
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            refresh_q  <= (state_d == StNotify);
            pending_q  <= pending_d;
            err_q      <= err_d;
        end
    end

    assign refresh_image = refresh_q;
    assign rd_x          = rd_q.x;
    assign rd_y          = rd_q.y;
    assign rd_dir        = rd_q.dir;
    assign rd_vis        = rd_q.vis;
    assign pending       = pending_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_sprite_position_table.sv
// Directed bench for sprite_position_table; bounds-check cases follow SPRITE_BOUNDS_CHECK_EN.
module tb_sprite_position_table;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [31:0] position_table_in = '0;
    logic        frame_start = 1'b0;
    logic        refresh_image;
    logic [2:0]  rd_id = '0;
    logic [9:0]  rd_x;
    logic [8:0]  rd_y;
    logic [2:0]  rd_dir;
    logic        rd_vis;
    logic        pending;
    logic [7:0]  err_count;

    int   checks = 0;
    int   errors = 0;
    logic tog = 1'b0;
    int   highs;

    sprite_position_table #(
        .X_MAX(639),
        .Y_MAX(479),
        .PULSE_LEN(4)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .position_table_in(position_table_in),
        .frame_start(frame_start),
        .refresh_image(refresh_image),
        .rd_id(rd_id),
        .rd_x(rd_x),
        .rd_y(rd_y),
        .rd_dir(rd_dir),
        .rd_vis(rd_vis),
        .pending(pending),
        .err_count(err_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one command word and advance one clock.
    task automatic wr(input logic [2:0] id, input logic [9:0] x, input logic [8:0] y,
                      input logic [2:0] dir, input logic vis);
        tog = ~tog;
        position_table_in = {tog, id, x, y, dir, vis, 5'b0};
        step();
    endtask

    task automatic commit_wait();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (7) step();
    endtask

    initial begin
        repeat (2) step();
        chk("rst_refresh", 32'(refresh_image), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_rd_x", 32'(rd_x), 0);
        reset_reset_n = 1'b1;
        step();

        // Basic write, commit and notify pulse
        rd_id = 3'd2;
        wr(3'd2, 10'd100, 9'd50, 3'd3, 1'b1);
        chk("pend_1clk", 32'(pending), 0);
        step();
        chk("pend_2clk", 32'(pending), 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("commit_refresh_lo", 32'(refresh_image), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("notify_hi", 32'(refresh_image), 1);
        end
        step();
        chk("notify_end_lo", 32'(refresh_image), 0);
        chk("rd_x_id2", 32'(rd_x), 100);
        chk("rd_y_id2", 32'(rd_y), 50);
        chk("rd_dir_id2", 32'(rd_dir), 3);
        chk("rd_vis_id2", 32'(rd_vis), 1);
        chk("pend_cleared", 32'(pending), 0);

        // Frame with nothing pending still pulses, bank untouched
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (refresh_image) highs++;
        end
        chk("idle_pulse_len", 32'(highs), 4);
        chk("idle_rd_x", 32'(rd_x), 100);

        // Write coinciding with COMMIT is deferred to the next frame
        rd_id = 3'd5;
        wr(3'd5, 10'd10, 9'd11, 3'd1, 1'b0);
        step();
        commit_wait();
        chk("id5_old", 32'(rd_x), 10);
        tog = ~tog;
        position_table_in = {tog, 3'd5, 10'd20, 9'd21, 3'd2, 1'b1, 5'b0};
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (7) step();
        chk("coincide_keep_old", 32'(rd_x), 10);
        chk("coincide_pending", 32'(pending), 1);
        commit_wait();
        chk("coincide_new_x", 32'(rd_x), 20);
        chk("coincide_new_vis", 32'(rd_vis), 1);
        chk("coincide_pend_clr", 32'(pending), 0);

        // Last write wins
        rd_id = 3'd3;
        wr(3'd3, 10'd1, 9'd1, 3'd1, 1'b1);
        wr(3'd3, 10'd639, 9'd479, 3'd7, 1'b0);
        step();
        commit_wait();
        chk("lww_x", 32'(rd_x), 639);
        chk("lww_y", 32'(rd_y), 479);
        chk("lww_dir", 32'(rd_dir), 7);

        // frame_start on NOTIFY clock 2 restarts the sequence
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("rs_notify1", 32'(refresh_image), 1);
        step();
        chk("rs_notify2", 32'(refresh_image), 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("rs_commit_lo", 32'(refresh_image), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rs_notify_hi", 32'(refresh_image), 1);
        end
        step();
        chk("rs_end_lo", 32'(refresh_image), 0);

        // Out-of-range coordinates
        rd_id = 3'd6;
        wr(3'd6, 10'd700, 9'd7, 3'd0, 1'b1);
        step();
`ifdef SPRITE_BOUNDS_CHECK_EN
        chk("bad_x_pending", 32'(pending), 0);
        chk("bad_x_err", 32'(err_count), 1);
        commit_wait();
        chk("bad_x_unchanged", 32'(rd_x), 0);
        wr(3'd6, 10'd5, 9'd500, 3'd0, 1'b1);
        step();
        chk("bad_y_err", 32'(err_count), 2);
        for (int i = 0; i < 298; i++) begin
            wr(3'd1, 10'd1000, 9'd0, 3'd0, 1'b0);
        end
        repeat (2) step();
        chk("err_saturate", 32'(err_count), 255);
`else
        chk("nochk_pending", 32'(pending), 1);
        commit_wait();
        chk("nochk_x", 32'(rd_x), 700);
        chk("nochk_err", 32'(err_count), 0);
`endif

        // Reset in the middle of NOTIFY
        rd_id = 3'd2;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("pre_rst_refresh", 32'(refresh_image), 1);
        reset_reset_n = 1'b0;
        position_table_in = '0;
        tog = 1'b0;
        #1;
        chk("rst_async_refresh", 32'(refresh_image), 0);
        chk("rst_async_pending", 32'(pending), 0);
        #2;
        reset_reset_n = 1'b1;
        step();
        chk("post_rst_x", 32'(rd_x), 0);
        chk("post_rst_y", 32'(rd_y), 0);
        chk("post_rst_dir", 32'(rd_dir), 0);
        chk("post_rst_vis", 32'(rd_vis), 0);
        chk("post_rst_err", 32'(err_count), 0);
        step();
        chk("post_rst_no_write", 32'(pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
